// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS control unit.
// Opcodes, funct codes, ALU codes, FSM states and datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: fixed add/sub classes or funct-driven R-type ops.
// Unknown funct falls back to add.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (1'b1)
      (alu_op == ALUOP_SUB): alu_control = ALU_SUB;
      (alu_op == ALUOP_FUNCT): begin
        unique case (1'b1)
          (funct == FN_SUB): alu_control = ALU_SUB;
          (funct == FN_AND): alu_control = ALU_AND;
          (funct == FN_OR):  alu_control = ALU_OR;
          (funct == FN_SLT): alu_control = ALU_SLT;
          default:           alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the shared multicycle MIPS datapath.
// Write enables are gated by rst_n so an async reset aborts any write at once.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INST_WIDTH-1:0] instr,
  input  logic                  zero,
  output logic                  iord,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  branch,
  output logic                  pc_en,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            alu_control,
  output logic [1:0]            pc_src,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic [3:0]            state
);

  state_t     state_q;
  state_t     state_d;
  alu_op_t    alu_op;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ir_w;
  logic       pc_w;
  logic       br;
  logic       rw;
  logic       mw;
  logic       unused_instr_bits;

  assign opcode            = instr[31:26];
  assign funct             = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    iord       = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    br         = 1'b0;
    rw         = 1'b0;
    mw         = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    pc_src     = PCSRC_ALU;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALUOP_ADD;
    unique case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        ir_w      = 1'b1;
        pc_w      = 1'b1;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):    state_d = S_MEMADR;
          (opcode == OP_RTYPE): state_d = S_EXECUTE;
          (opcode == OP_BEQ):   state_d = S_BRANCH;
          (opcode == OP_ADDI):  state_d = S_ADDIEXEC;
          (opcode == OP_J):     state_d = S_JUMP;
          default:              state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LW)      state_d = S_MEMREAD;
        else if (opcode == OP_SW) state_d = S_MEMWRITE;
        else                      state_d = S_FETCH;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        rw         = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        iord = 1'b1;
        mw   = 1'b1;
      end
      S_EXECUTE: begin
        state_d   = S_ALUWB;
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst = 1'b1;
        rw      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PCSRC_ALUOUT;
        br        = 1'b1;
      end
      S_ADDIEXEC: begin
        state_d   = S_ADDIWB;
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: rw = 1'b1;
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_w   = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

  assign ir_write  = ir_w & rst_n;
  assign pc_write  = pc_w & rst_n;
  assign branch    = br & rst_n;
  assign pc_en     = (pc_w | (br & zero)) & rst_n;
  assign reg_write = rw & rst_n;
  assign mem_write = mw & rst_n;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction state walks
// and full output vectors compared with a table-driven instruction model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        zero = 1'b0;
  logic        iord, ir_write, pc_write, branch, pc_en, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_control;
  logic        reg_dst, mem_to_reg, reg_write, mem_write;
  logic [3:0]  state;
  logic [16:0] outs;

  int checks = 0;
  int fails  = 0;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00;
  localparam logic [5:0] BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02;

  multicycle_controller #(.INST_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .branch(branch), .pc_en(pc_en), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control),
    .pc_src(pc_src), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .mem_write(mem_write), .state(state)
  );

  always #5 clk = ~clk;

  assign outs = {iord, ir_write, pc_write, branch, pc_en, alu_src_a,
                 alu_src_b, alu_control, pc_src, reg_dst, mem_to_reg,
                 reg_write, mem_write};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // Instruction class -> sequence of visited states.
  function automatic int seq_len(logic [5:0] op);
    case (op)
      LW:             return 5;
      SW, RT, ADDI:   return 4;
      BEQ, JMP:       return 3;
      default:        return 2;
    endcase
  endfunction

  function automatic int seq_state(logic [5:0] op, int i);
    int s [5];
    s = '{0, 1, 0, 0, 0};
    case (op)
      LW:   s = '{0, 1, 2, 3, 4};
      SW:   s = '{0, 1, 2, 5, 0};
      RT:   s = '{0, 1, 6, 7, 0};
      ADDI: s = '{0, 1, 9, 10, 0};
      BEQ:  s = '{0, 1, 8, 0, 0};
      JMP:  s = '{0, 1, 11, 0, 0};
      default: s = '{0, 1, 0, 0, 0};
    endcase
    return s[i];
  endfunction

  function automatic logic [2:0] funct_alu(logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2a:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [16:0] exp_outs(int st, logic [5:0] fn,
                                           logic z);
    logic e_iord = 0, e_irw = 0, e_pcw = 0, e_br = 0, e_srca = 0;
    logic e_rd = 0, e_m2r = 0, e_rw = 0, e_mw = 0;
    logic [1:0] e_srcb = 2'b00, e_pcs = 2'b00;
    logic [2:0] e_alu = 3'b010;
    case (st)
      0:  begin e_irw = 1; e_pcw = 1; e_srcb = 2'b01; end
      1:  e_srcb = 2'b11;
      2:  begin e_srca = 1; e_srcb = 2'b10; end
      3:  e_iord = 1;
      4:  begin e_rw = 1; e_m2r = 1; end
      5:  begin e_iord = 1; e_mw = 1; end
      6:  begin e_srca = 1; e_alu = funct_alu(fn); end
      7:  begin e_rd = 1; e_rw = 1; end
      8:  begin e_srca = 1; e_alu = 3'b110; e_pcs = 2'b01; e_br = 1; end
      9:  begin e_srca = 1; e_srcb = 2'b10; end
      10: e_rw = 1;
      11: begin e_pcs = 2'b10; e_pcw = 1; end
      default: ;
    endcase
    return {e_iord, e_irw, e_pcw, e_br, e_pcw | (e_br & z), e_srca,
            e_srcb, e_alu, e_pcs, e_rd, e_m2r, e_rw, e_mw};
  endfunction

  // Called at a sampling point with the DUT in FETCH; returns there.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z,
                           string name);
    logic [31:0] r;
    int n;
    int es;
    r = $urandom();
    instr = {op, r[19:0], fn};
    zero = z;
    n = seq_len(op);
    for (int i = 0; i < n; i++) begin
      es = seq_state(op, i);
      checks++;
      if (state !== 4'(es)) begin
        fails++;
        $display("FAIL %s state step %0d: got %0d expected %0d",
                 name, i, state, es);
      end
      checks++;
      if (outs !== exp_outs(es, fn, z)) begin
        fails++;
        $display("FAIL %s outputs step %0d: got %b expected %b",
                 name, i, outs, exp_outs(es, fn, z));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (state !== 4'd0) begin
      fails++;
      $display("FAIL reset_state: got %0d expected 0", state);
    end
    checks++;
    if (outs !== {6'b0, 2'b01, 3'b010, 6'b0}) begin
      fails++;
      $display("FAIL reset_outputs: got %b expected %b", outs,
               {6'b0, 2'b01, 3'b010, 6'b0});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({ir_write, pc_write, pc_en} !== 3'b111) begin
      fails++;
      $display("FAIL reset_release_fetch: got %b expected 111",
               {ir_write, pc_write, pc_en});
    end
  endtask

  task automatic test_lw;
    run_instr(LW, 6'($urandom()), 1'b0, "lw");
  endtask

  task automatic test_sw;
    run_instr(SW, 6'($urandom()), 1'b1, "sw");
  endtask

  task automatic test_rtype;
    logic [5:0] fns [6];
    fns = '{6'h22, 6'h24, 6'h25, 6'h2a, 6'h20, 6'h3f};
    foreach (fns[i]) run_instr(RT, fns[i], 1'($urandom()), "rtype");
    run_instr(ADDI, 6'($urandom()), 1'b0, "addi");
  endtask

  task automatic test_beq;
    run_instr(BEQ, 6'($urandom()), 1'b1, "beq_taken");
    run_instr(BEQ, 6'($urandom()), 1'b0, "beq_not_taken");
    instr = {BEQ, 26'h1234};
    zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pc_en !== 1'b0) begin
      fails++;
      $display("FAIL beq_pc_en_z0: got %b expected 0", pc_en);
    end
    zero = 1'b1;
    #1;
    checks++;
    if (pc_en !== 1'b1) begin
      fails++;
      $display("FAIL beq_pc_en_follow: got %b expected 1", pc_en);
    end
    zero = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      fails++;
      $display("FAIL beq_return: got %0d expected 0", state);
    end
  endtask

  task automatic test_jump_nop;
    run_instr(JMP, 6'($urandom()), 1'($urandom()), "jump");
    run_instr(6'h3f, 6'($urandom()), 1'($urandom()), "nop_op");
  endtask

  task automatic test_reset_midinstr;
    instr = {SW, 26'h0abcd};
    zero = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({state, mem_write} !== {4'd5, 1'b1}) begin
      fails++;
      $display("FAIL midrst_memwrite: got %0d/%b expected 5/1",
               state, mem_write);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({state, mem_write} !== {4'd0, 1'b0}) begin
      fails++;
      $display("FAIL midrst_async: got %0d/%b expected 0/0",
               state, mem_write);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({state, ir_write, pc_write, branch, pc_en, reg_write, mem_write}
        !== 10'd0) begin
      fails++;
      $display("FAIL midrst_held: got %0d %b expected 0 000000", state,
               {ir_write, pc_write, branch, pc_en, reg_write, mem_write});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({state, ir_write, pc_write} !== {4'd0, 2'b11}) begin
      fails++;
      $display("FAIL midrst_release: got %0d %b expected 0 11",
               state, {ir_write, pc_write});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (state !== 4'd0) begin
      fails++;
      $display("FAIL midrst_resume: got %0d expected 0", state);
    end
  endtask

  task automatic test_random;
    logic [5:0] ops [6];
    logic [5:0] op;
    logic [5:0] fn;
    ops = '{LW, SW, RT, BEQ, ADDI, JMP};
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        do op = 6'($urandom_range(0, 63));
        while (op inside {LW, SW, RT, BEQ, ADDI, JMP});
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 1) == 1)
        fn = funct_alu(6'h0) == 3'b010 ?
             (6'h20 | 6'($urandom_range(0, 10))) : 6'h20;
      else
        fn = 6'($urandom());
      run_instr(op, fn, 1'($urandom()), "random");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_beq();
    test_jump_nop();
    test_reset_midinstr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
